controle_seq: RTL and testbench
===============================

Name: controle_seq

Overview:
- Parametrised microprogrammed successor to the fixed-step register/ULA controller.
- Owns its own step counter and a writable microcode table, DEPTH words deep, which replaces the hard-coded count decode.
- Drives NREG register-control channels plus the ULA opcode.
- Has a start/busy/done handshake, an abort path, and a per-word "use requested op" bit so one program serves every ULA operation.

Parameters:
- NREG, 3: number of register-control channels (channel 0 = X, 1 = Y, 2 = Z).
- DEPTH, 8: microcode words, power of two, >= 2.
- AW, $clog2(DEPTH): step/address width.
- Derived, not overridable: W = 3*NREG+2, microcode word width.

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin program run; sampled in IDLE only
- abort  in  1  terminate run; sampled in RUN only
- op  in  3  requested ULA op (ADD=000 SUB=001 MAIOR=010 MENOR=011 IGUAL=100 XOR=101 AND=110), latched on start
- prog_we  in  1  microcode write enable; honoured in IDLE only
- prog_addr  in  AW  microcode write address
- prog_data  in  W  microcode word
- Treg  out  3*NREG  channel i control at [3i+2:3i]; HOLD=000 LOAD=001 SHIFTR=010 SHIFTL=011 RESET=100
- Tula  out  3  ULA opcode
- step  out  AW  index of word currently driven
- busy  out  1  high in RUN and FLUSH
- done  out  1  one-cycle completion pulse

Behaviour:
- Word layout: [3*NREG-1:0] channel codes; bit 3*NREG = use_op; bit 3*NREG+1 = last.
- All outputs registered.
- Reset values: Treg all HOLD, Tula=ADD, step=0, busy=0, done=0, state IDLE, latched op=ADD.
- Reset table image: every word all-HOLD, use_op=0; last=1 only in word DEPTH-1.
- Reset mid-run returns to this exact state in one edge; no done pulse is produced.
- IDLE:
  - Outputs HOLD/ADD.
  - prog_we writes table[prog_addr] at the edge.
  - start at edge k: latch op, step<=0, state->RUN, busy<=1.
  - start and prog_we together: the write commits and the run reads the new content, since the first read is at edge k+1.
- RUN:
  - Edge k+1+j drives word j: Treg<=channel fields, Tula<=use_op ? latched op : ADD, step<=j.
  - If word j has last=1, or j==DEPTH-1 (wrap forbidden), state->IDLE at edge k+2+j.
  - At edge k+2+j: Treg<=HOLD, Tula<=ADD, busy<=0, done<=1 for exactly one cycle.
  - Otherwise the word index increments.
- RUN, other inputs:
  - prog_we ignored; table unchanged.
  - start ignored.
  - op changes after latch have no effect.
- abort in RUN at edge e:
  - state->FLUSH; at e, Treg<=all RESET, Tula<=ADD.
  - Edge e+1: state->IDLE, outputs HOLD/ADD, busy<=0, done stays 0.
  - abort in IDLE or FLUSH is ignored.
  - abort and last on the same edge: abort wins.
- Latency: start to first word = 1 edge; program of L+1 words (last at index L) gives busy for L+2 cycles, done at edge k+2+L.
- Minimum idle gap: done cycle is IDLE, so start may be asserted during done and is accepted.

Test Plan:
- Reset, then 3 idle cycles -> Treg=000_000_000 (Z,Y,X), Tula=000, busy=0, done=0; word 7 last=1 per reset image (run program of all HOLD -> done at edge k+9).
- Program words 0..5 with X/Y/Z = (LOAD,RESET,RESET),(LOAD,LOAD,HOLD),(RESET,LOAD,RESET),(RESET,SHIFTR,RESET),(RESET,RESET,LOAD),(HOLD,HOLD,HOLD); last on word 5, use_op on word 4; start with op=SUB -> Treg sequence matches over 6 cycles, Tula=001 only at step 4, done pulse at edge k+7.
- Same program, start with op=XOR and op toggled to AND mid-run -> step-4 Tula=101.
- abort asserted at step 2 -> next cycle Treg all RESET (100_100_100), then HOLD, busy low, done never high.
- prog_we to word 3 during RUN -> ignored; rerun shows original word 3. Start and prog_we in the same IDLE cycle writing word 0 -> new word 0 appears at first step.
- reset asserted at step 3 -> next edge all outputs at reset values, table reinitialised to reset image; start on done cycle accepted -> back-to-back runs with no gap.

Source files
------------

// File: rtl/controle_seq_if.sv
// controle_seq_if: handshake, microcode-load and control-output bundle of the sequencer
interface controle_seq_if #(parameter int NREG = 3, parameter int DEPTH = 8);
  localparam int AW = $clog2(DEPTH);
  localparam int W = 3 * NREG + 2;
  logic start;
  logic abort;
  logic [2:0] op;
  logic prog_we;
  logic [AW-1:0] prog_addr;
  logic [W-1:0] prog_data;
  logic [3*NREG-1:0] Treg;
  logic [2:0] Tula;
  logic [AW-1:0] step;
  logic busy;
  logic done;
  modport master (output start, abort, op, prog_we, prog_addr, prog_data,
                  input Treg, Tula, step, busy, done);
  modport slave (input start, abort, op, prog_we, prog_addr, prog_data,
                 output Treg, Tula, step, busy, done);
endinterface

// File: rtl/controle_seq.sv
// controle_seq: microprogrammed register/ULA sequencer with writable table, start/abort handshake
module controle_seq #(
  parameter int NREG = 3,
  parameter int DEPTH = 8
) (
  input logic clock,
  input logic reset,
  controle_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = 3 * NREG + 2;
  localparam logic [3*NREG-1:0] ALL_RST = {NREG{3'b100}};
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  logic fin;
  logic [2:0] opl;
  logic [W-1:0] w;
  always_comb w = mem[ptr];
  // fin marks that the last word is on the outputs; the following edge completes the run
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= (i == DEPTH - 1) ? W'(1) << (W - 1) : '0;
      state <= IDLE;
      ptr <= '0;
      fin <= 1'b0;
      opl <= 3'b000;
      bus.Treg <= '0;
      bus.Tula <= 3'b000;
      bus.step <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
          if (bus.start) begin
            opl <= bus.op;
            ptr <= '0;
            fin <= 1'b0;
            bus.step <= '0;
            bus.busy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state <= FLUSH;
            bus.Treg <= ALL_RST;
            bus.Tula <= 3'b000;
          end else if (fin) begin
            state <= IDLE;
            bus.Treg <= '0;
            bus.Tula <= 3'b000;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            bus.Treg <= w[3*NREG-1:0];
            bus.Tula <= w[3*NREG] ? opl : 3'b000;
            bus.step <= ptr;
            fin <= w[W-1] || ptr == AW'(DEPTH - 1);
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          bus.Treg <= '0;
          bus.Tula <= 3'b000;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_controle_seq.sv
// tb_controle_seq: randomized scoreboard bench for controle_seq against a table-walking model
module tb_controle_seq;
  localparam int NREG = 3;
  localparam int DEPTH = 8;
  localparam int AW = $clog2(DEPTH);
  localparam int W = 3 * NREG + 2;
  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHR = 3'd2, SHL = 3'd3, RST = 3'd4;

  typedef struct packed {
    logic [3*NREG-1:0] t;
    logic [2:0] u;
    logic [AW-1:0] s;
    logic b;
    logic d;
    logic cs;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic armed = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  logic [W-1:0] tbl [DEPTH];

  controle_seq_if #(.NREG(NREG), .DEPTH(DEPTH)) bus ();
  controle_seq #(.NREG(NREG), .DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input bit l, input bit u, input logic [2:0] x, input logic [2:0] y, input logic [2:0] z);
    return {l, u, z, y, x};
  endfunction

  task automatic tbl_reset();
    for (int i = 0; i < DEPTH; i++) tbl[i] = (i == DEPTH - 1) ? mk(1, 0, HOLD, HOLD, HOLD) : '0;
  endtask

  always @(negedge clock) begin
    if (armed && (bus.busy || bus.done)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output treg=%0h busy=%0b done=%0b want=none t=%0t", bus.Treg, bus.busy, bus.done, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("treg", 32'(bus.Treg), 32'(e.t));
        chk("tula", 32'(bus.Tula), 32'(e.u));
        if (e.cs) chk("step", 32'(bus.step), 32'(e.s));
        chk("busy", 32'(bus.busy), 32'(e.b));
        chk("done", 32'(bus.done), 32'(e.d));
      end
    end else if (armed) begin
      chk("idle_treg", 32'(bus.Treg), 0);
      chk("idle_tula", 32'(bus.Tula), 0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic prog(input int a, input logic [W-1:0] d);
    bus.prog_we = 1'b1;
    bus.prog_addr = AW'(a);
    bus.prog_data = d;
    tick();
    bus.prog_we = 1'b0;
    tbl[a] = d;
  endtask

  task automatic check_reset_state();
    chk("rst_treg", 32'(bus.Treg), 0);
    chk("rst_tula", 32'(bus.Tula), 0);
    chk("rst_step", 32'(bus.step), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
  endtask

  // Returns in the done cycle (normal end), or in the first IDLE cycle after an abort or reset.
  task automatic run(input logic [2:0] o, input int ab_in, input int rs, input bit tog,
                     input bit wr_mid, input bit wr0, input logic [W-1:0] d0);
    int L = 0;
    int ab = ab_in;
    if (wr0) tbl[0] = d0;
    while (!tbl[L][W-1] && L < DEPTH - 1) L++;
    if (ab > L) ab = -1;
    q.push_back('{t: '0, u: 3'd0, s: '0, b: 1'b1, d: 1'b0, cs: 1'b1});
    for (int j = 0; j <= L; j++) begin
      if ((ab >= 0 && j > ab) || (rs >= 0 && j > rs)) break;
      q.push_back('{t: tbl[j][3*NREG-1:0], u: tbl[j][3*NREG] ? o : 3'd0, s: AW'(j), b: 1'b1, d: 1'b0, cs: 1'b1});
    end
    if (ab >= 0) q.push_back('{t: {NREG{RST}}, u: 3'd0, s: '0, b: 1'b1, d: 1'b0, cs: 1'b0});
    else if (rs < 0) q.push_back('{t: '0, u: 3'd0, s: '0, b: 1'b0, d: 1'b1, cs: 1'b0});
    bus.op = o;
    bus.start = 1'b1;
    if (wr0) begin
      bus.prog_we = 1'b1;
      bus.prog_addr = '0;
      bus.prog_data = d0;
    end
    tick();
    bus.start = 1'b0;
    bus.prog_we = 1'b0;
    if (tog) bus.op = 3'b110;
    for (int j = 0; j <= L; j++) begin
      tick();
      bus.prog_we = 1'b0;
      if (wr_mid && j == 1) begin
        bus.prog_we = 1'b1;
        bus.prog_addr = AW'(3);
        bus.prog_data = W'($urandom);
      end
      if (j == ab) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.prog_we = 1'b0;
        tick();
        return;
      end
      if (j == rs) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.prog_we = 1'b0;
        check_reset_state();
        tbl_reset();
        return;
      end
    end
    tick();
    bus.prog_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op = 3'd0;
    bus.prog_we = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    tbl_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    armed = 1'b1;
    repeat (3) tick();
    check_reset_state();
    run(3'(($urandom_range(0, 6))), -1, -1, 0, 0, 0, '0);
    repeat (2) tick();
    prog(0, mk(0, 0, LOAD, RST, RST));
    prog(1, mk(0, 0, LOAD, LOAD, HOLD));
    prog(2, mk(0, 0, RST, LOAD, RST));
    prog(3, mk(0, 0, RST, SHR, RST));
    prog(4, mk(0, 1, RST, RST, LOAD));
    prog(5, mk(1, 0, HOLD, HOLD, HOLD));
    run(3'b001, -1, -1, 0, 0, 0, '0);
    tick();
    run(3'b101, -1, -1, 1, 0, 0, '0);
    tick();
    run(3'b001, 2, -1, 0, 0, 0, '0);
    run(3'b010, -1, -1, 0, 1, 0, '0);
    tick();
    run(3'b010, -1, -1, 0, 0, 0, '0);
    tick();
    run(3'b011, -1, -1, 0, 0, 1, mk(0, 1, SHL, LOAD, SHR));
    tick();
    run(3'b100, -1, 3, 0, 0, 0, '0);
    run(3'b000, -1, -1, 0, 0, 0, '0);
    run(3'b110, -1, -1, 0, 0, 0, '0);
    run(3'b001, 5, -1, 0, 0, 0, '0);
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          logic [W-1:0] d;
          d = W'($urandom);
          d[W-1] = ($urandom_range(0, 3) == 0);
          prog(i, d);
        end
      end
      run(3'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : -1,
          -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end
    repeat (3) tick();
    chk("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
